// File: rtl/irl_load_sequencer.sv
// irl_load_sequencer: load pointer and slot bank for the IRL stage.
// Captures data_in into slot[y] on load strobes, replays the loaded slots
// one per cycle on a run strobe, then self-clears.
// Optional feature macro: IRL_PARITY_EN adds a stored even-parity bit per
// slot and the o_out_par output.
module irl_load_sequencer #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned SLOTS  = 5
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_d,
   input  logic [1:0]        i_w,
   input  logic [DATA_W-1:0] i_data_in,
   output logic [2:0]        o_y,
   output logic              o_full,
   output logic              o_busy,
   output logic              o_out_valid,
   output logic [DATA_W-1:0] o_out_data,
   output logic              o_done,
`ifdef IRL_PARITY_EN
   output logic              o_out_par,
`endif
   output logic              o_ovf
);

`ifdef IRL_PARITY_EN
   localparam int unsigned PAR_W = 1;
`else
   localparam int unsigned PAR_W = 0;
`endif
   localparam int unsigned SW = DATA_W + PAR_W;

   localparam logic [2:0] Y_FULL = 3'(SLOTS);
   localparam logic [2:0] Y_LAST = 3'(SLOTS - 1);

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_FULL,
      ST_PLAY
   } state_t;

   state_t            r_state;
   logic [2:0]        r_y;
   logic [2:0]        r_idx;
   logic [1:0]        r_wq;
   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic              r_done;
   logic              r_ovf;
   logic [SW-1:0]     r_slot [SLOTS];
`ifdef IRL_PARITY_EN
   logic              r_par;
   logic              w_par_nxt;
`endif

   state_t            w_state_nxt;
   logic [2:0]        w_y_nxt;
   logic [2:0]        w_idx_nxt;
   logic              w_valid_nxt;
   logic [DATA_W-1:0] w_data_nxt;
   logic              w_done_nxt;
   logic              w_ovf_nxt;
   logic              w_wr_en;
   logic              w_strobe;
   logic [2:0]        w_rd_idx;
   logic [SW-1:0]     w_rd_word;
   logic [SW-1:0]     w_wr_word;

   // Rising edge of the strobe command; a held 11 counts once.
   assign w_strobe = (i_w == 2'b11) && (r_wq != 2'b11);

`ifdef IRL_PARITY_EN
   assign w_wr_word = {^i_data_in, i_data_in};
`else
   assign w_wr_word = i_data_in;
`endif

   // Read index: slot 0 when launching a replay, r_idx while replaying.
   // Guarded so the terminating PLAY cycle (r_idx == y) never reads past the bank.
   assign w_rd_idx  = (r_state == ST_PLAY && r_idx < Y_FULL) ? r_idx : '0;
   assign w_rd_word = r_slot[w_rd_idx];

   // Next-state and registered-output logic.
   always_comb begin
      w_state_nxt = r_state;
      w_y_nxt     = r_y;
      w_idx_nxt   = r_idx;
      w_valid_nxt = r_valid;
      w_data_nxt  = r_data;
      w_done_nxt  = 1'b0;
      w_ovf_nxt   = 1'b0;
      w_wr_en     = 1'b0;
`ifdef IRL_PARITY_EN
      w_par_nxt   = r_par;
`endif
      case (r_state)
         ST_LOAD, ST_FULL: begin
            w_valid_nxt = 1'b0;
            if (i_w == 2'b10) begin
               w_y_nxt     = '0;
               w_state_nxt = ST_LOAD;
            end else if (w_strobe) begin
               if (!i_d) begin
                  if (r_state == ST_LOAD) begin
                     w_wr_en = 1'b1;
                     w_y_nxt = r_y + 3'd1;
                     if (r_y == Y_LAST) begin
                        w_state_nxt = ST_FULL;
                     end
                  end else begin
                     w_ovf_nxt = 1'b1;
                  end
               end else if (r_y == '0) begin
                  w_done_nxt = 1'b1;
               end else begin
                  w_state_nxt = ST_PLAY;
                  w_valid_nxt = 1'b1;
                  w_data_nxt  = w_rd_word[DATA_W-1:0];
`ifdef IRL_PARITY_EN
                  w_par_nxt   = w_rd_word[DATA_W];
`endif
                  w_idx_nxt   = 3'd1;
               end
            end
         end
         ST_PLAY: begin
            if (r_idx < r_y) begin
               w_valid_nxt = 1'b1;
               w_data_nxt  = w_rd_word[DATA_W-1:0];
`ifdef IRL_PARITY_EN
               w_par_nxt   = w_rd_word[DATA_W];
`endif
               w_idx_nxt   = r_idx + 3'd1;
            end else begin
               w_valid_nxt = 1'b0;
               w_done_nxt  = 1'b1;
               w_y_nxt     = '0;
               w_state_nxt = ST_LOAD;
            end
         end
         default: begin
            w_state_nxt = ST_LOAD;
         end
      endcase
   end

   // Control/state registers with synchronous reset.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= ST_LOAD;
         r_y     <= '0;
         r_idx   <= '0;
         r_wq    <= 2'b00;
         r_valid <= 1'b0;
         r_data  <= '0;
         r_done  <= 1'b0;
         r_ovf   <= 1'b0;
`ifdef IRL_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_y     <= w_y_nxt;
         r_idx   <= w_idx_nxt;
         r_wq    <= i_w;
         r_valid <= w_valid_nxt;
         r_data  <= w_data_nxt;
         r_done  <= w_done_nxt;
         r_ovf   <= w_ovf_nxt;
`ifdef IRL_PARITY_EN
         r_par   <= w_par_nxt;
`endif
      end
   end

   // Slot bank: cleared on reset, written at the load pointer on a load strobe.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         for (int unsigned i = 0; i < SLOTS; i++) begin
            r_slot[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_slot[r_y] <= w_wr_word;
      end
   end

   assign o_y         = r_y;
   assign o_full      = (r_state == ST_FULL);
   assign o_busy      = (r_state == ST_PLAY);
   assign o_out_valid = r_valid;
   assign o_out_data  = r_data;
   assign o_done      = r_done;
   assign o_ovf       = r_ovf;
`ifdef IRL_PARITY_EN
   assign o_out_par   = r_par;
`endif

endmodule

// File: tb/tb_irl_load_sequencer.sv
// tb_irl_load_sequencer: directed scenarios followed by random traffic, every
// cycle compared against a queue-based behavioural model of the sequencer.
// Honours IRL_PARITY_EN the same way as the design.
module tb_irl_load_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       d   = 1'b0;
   logic [1:0] w   = 2'b00;
   logic [7:0] din = 8'h00;

   logic [2:0] y;
   logic       full, busy, out_valid, done, ovf;
   logic [7:0] out_data;
`ifdef IRL_PARITY_EN
   logic       out_par;
`endif

   int unsigned vectors    = 0;
   int unsigned miscompares = 0;

   irl_load_sequencer #(.DATA_W(8), .SLOTS(5)) dut (
      .i_clock     (clk),
      .i_reset     (rst),
      .i_d         (d),
      .i_w         (w),
      .i_data_in   (din),
      .o_y         (y),
      .o_full      (full),
      .o_busy      (busy),
      .o_out_valid (out_valid),
      .o_out_data  (out_data),
      .o_done      (done),
`ifdef IRL_PARITY_EN
      .o_out_par   (out_par),
`endif
      .o_ovf       (ovf)
   );

   always #5 clk = ~clk;

   // Reference model: a count of loaded words, a word store and a replay queue.
   int         m_cnt;
   logic [8:0] m_mem [5];
   logic [1:0] m_wq;
   logic [8:0] m_replay [$];
   logic       m_busy, m_valid, m_done, m_ovf, m_par;
   logic [7:0] m_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_edge();
      logic       strobe;
      logic [8:0] word;
      m_done = 1'b0;
      m_ovf  = 1'b0;
      if (rst) begin
         m_cnt = 0;
         foreach (m_mem[i]) m_mem[i] = '0;
         m_wq = 2'b00;
         m_replay.delete();
         m_busy = 0; m_valid = 0; m_data = 0; m_par = 0;
         return;
      end
      strobe = (w == 2'b11) && (m_wq != 2'b11);
      m_wq = w;
      if (m_busy) begin
         if (m_replay.size() > 0) begin
            word = m_replay.pop_front();
            m_data = word[7:0]; m_par = word[8]; m_valid = 1;
         end else begin
            m_valid = 0; m_busy = 0; m_done = 1; m_cnt = 0;
         end
      end else if (w == 2'b10) begin
         m_cnt = 0;
      end else if (strobe && !d) begin
         if (m_cnt < 5) begin
            m_mem[m_cnt] = {^din, din};
            m_cnt++;
         end else begin
            m_ovf = 1;
         end
      end else if (strobe && d) begin
         if (m_cnt == 0) begin
            m_done = 1;
         end else begin
            for (int i = 0; i < m_cnt; i++) m_replay.push_back(m_mem[i]);
            word = m_replay.pop_front();
            m_data = word[7:0]; m_par = word[8]; m_valid = 1; m_busy = 1;
         end
      end
   endtask

   task automatic compare_all();
      chk("y",         32'(y),         32'(m_cnt));
      chk("full",      32'(full),      32'(!m_busy && m_cnt == 5));
      chk("busy",      32'(busy),      32'(m_busy));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("out_data",  32'(out_data),  32'(m_data));
      chk("done",      32'(done),      32'(m_done));
      chk("ovf",       32'(ovf),       32'(m_ovf));
`ifdef IRL_PARITY_EN
      chk("out_par",   32'(out_par),   32'(m_par));
`endif
   endtask

   // One clock: apply inputs, advance the model on the edge, compare at negedge.
   task automatic step(input logic r, input logic dd, input logic [1:0] ww, input logic [7:0] dat);
      rst = r; d = dd; w = ww; din = dat;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic load_word(input logic [7:0] dat);
      step(0, 0, 2'b11, dat);
      step(0, 0, 2'b00, 8'h00);
   endtask

   initial begin
      int unsigned r;
      logic [1:0]  rw;
      // Reset held two cycles.
      step(1, 0, 2'b00, 8'h00);
      step(1, 0, 2'b00, 8'h00);
      // Five loads then one rejected load while full.
      for (int i = 1; i <= 5; i++) load_word(8'(i * 8'h11));
      chk("full_after_5", 32'(full), 32'd1);
      load_word(8'h66);
      // Replay all five, wait out the done pulse.
      step(0, 1, 2'b11, 8'h00);
      for (int i = 0; i < 7; i++) step(0, 1, 2'b00, 8'h00);
      // Two loads, clear, then run on empty.
      load_word(8'hA0);
      load_word(8'hB0);
      step(0, 0, 2'b10, 8'h00);
      step(0, 1, 2'b11, 8'h00);
      step(0, 0, 2'b00, 8'h00);
      // Held strobe counts once; clear right after a strobe.
      for (int i = 0; i < 4; i++) step(0, 0, 2'b11, 8'h5A);
      step(0, 0, 2'b00, 8'h00);
      step(0, 0, 2'b11, 8'hC3);
      step(0, 0, 2'b10, 8'h00);
      // Parity pattern then replay, reset in second PLAY cycle.
      load_word(8'h03);
      load_word(8'h07);
      load_word(8'h0F);
      step(0, 1, 2'b11, 8'h00);
      step(0, 1, 2'b00, 8'h00);
      step(1, 0, 2'b00, 8'h00);
      step(0, 0, 2'b00, 8'h00);
      step(0, 0, 2'b00, 8'h00);
      // Parity replay through to done.
      load_word(8'h03);
      load_word(8'h07);
      step(0, 1, 2'b11, 8'h00);
      for (int i = 0; i < 4; i++) step(0, 0, 2'b11, 8'h00);
      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         r = $urandom_range(0, 15);
         if (r < 7)       rw = 2'b11;
         else if (r < 12) rw = 2'b00;
         else if (r < 14) rw = 2'b01;
         else             rw = 2'b10;
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0), rw, 8'($urandom));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
